// File: rtl/multiplicador_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encoding and
// the width helper used to size the iteration counter.
package multiplicador_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Bits needed to hold values 0..value-1; evaluated at elaboration time.
    function automatic int clog2(input int value);
        int bits;
        int v;
        bits = 0;
        v    = value - 1;
        while (v > 0) begin
            bits++;
            v = v >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/multiplicador_datapath.sv
// Multiplier datapath: operand magnitude/sign capture, (WIDTH+1)-bit adder,
// 2*WIDTH shift register and final conditional negate into Produto.
module multiplicador_datapath #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               fix,
    input  logic               sinal,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [2*WIDTH-1:0] produto
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] produto_q, produto_d;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     sum;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        // Negating -2^(W-1) wraps to itself, which read as unsigned is the right magnitude.
        mag_a = (sinal && op_a[WIDTH-1]) ? -op_a : op_a;
        mag_b = (sinal && op_b[WIDTH-1]) ? -op_b : op_b;

        // Carry out of the add lands in the MSB after the right shift.
        sum = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_b_q})
                       : {1'b0, acc_q[2*WIDTH-1:WIDTH]};

        acc_d     = acc_q;
        mag_b_d   = mag_b_q;
        neg_d     = neg_q;
        produto_d = produto_q;

        if (load) begin
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            mag_b_d = mag_b;
            neg_d   = sinal & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        end else if (step) begin
            acc_d = {sum, acc_q[WIDTH-1:1]};
        end

        if (fix) begin
            produto_d = neg_q ? -acc_q : acc_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; all of it is reset, including the result register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q     <= '0;
            mag_b_q   <= '0;
            neg_q     <= 1'b0;
            produto_q <= '0;
        end else begin
            acc_q     <= acc_d;
            mag_b_q   <= mag_b_d;
            neg_q     <= neg_d;
            produto_q <= produto_d;
        end
    end

    assign produto = produto_q;

endmodule

// File: rtl/multiplicador_param.sv
// Sequential WIDTH x WIDTH shift-add multiplier with signed/unsigned mode.
// Holds the control FSM and iteration counter; arithmetic lives in the datapath.
module multiplicador_param
    import multiplicador_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               St,
    input  logic               Sinal,
    input  logic [WIDTH-1:0]   Multiplicador,
    input  logic [WIDTH-1:0]   Multiplicando,
    output logic               Idle,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Produto
);

    localparam int CW = clog2(WIDTH + 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load;
    logic          step;
    logic          fix;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (St) begin
                    load    = 1'b1;
                    cnt_d   = CW'(WIDTH);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                step  = 1'b1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                fix     = 1'b1;
                state_d = S_DONE;
            end
            // St seen here or while busy is dropped, not queued.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Idle = (state_q == S_IDLE);
    assign Busy = (state_q == S_CALC) || (state_q == S_FIX);
    assign Done = (state_q == S_DONE);

    multiplicador_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .fix     (fix),
        .sinal   (Sinal),
        .op_a    (Multiplicador),
        .op_b    (Multiplicando),
        .produto (Produto)
    );

endmodule

// File: tb/tb_multiplicador_param.sv
// Self-checking bench for multiplicador_param: WIDTH=16 and WIDTH=8 instances,
// table-driven products plus hand-written start/abort/hold sequences.
module tb_multiplicador_param;

    logic        clk = 1'b0;
    logic        rst;

    logic        st16, s16;
    logic [15:0] a16, b16;
    logic        idle16, busy16, done16;
    logic [31:0] p16;

    logic        st8, s8;
    logic [7:0]  a8, b8;
    logic        idle8, busy8, done8;
    logic [15:0] p8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multiplicador_param #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .St(st16), .Sinal(s16),
        .Multiplicador(a16), .Multiplicando(b16),
        .Idle(idle16), .Busy(busy16), .Done(done16), .Produto(p16)
    );

    multiplicador_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .St(st8), .Sinal(s8),
        .Multiplicador(a8), .Multiplicando(b8),
        .Idle(idle8), .Busy(busy8), .Done(done8), .Produto(p8)
    );

    typedef struct {
        string       nm;
        bit          w8;
        bit          sg;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Starts one operation, then follows it to Done, checking latency,
    // Idle/Busy every cycle, the single-cycle Done pulse and the held result.
    task automatic run_op(input bit w8, input bit sg, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp, input string nm);
        int          lat;
        bit          seen;
        bit          flags_ok;
        logic [31:0] prod;
        logic [2:0]  ibd;
        if (w8) begin
            st8 = 1'b1; s8 = sg; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            st16 = 1'b1; s16 = sg; a16 = a; b16 = b;
        end
        @(posedge clk); #1;
        // Operand and mode changes after the start edge must have no effect.
        st8 = 1'b0; st16 = 1'b0;
        a8 = ~a8; b8 = ~b8; a16 = ~a16; b16 = ~b16; s8 = ~s8; s16 = ~s16;
        seen = 1'b0; flags_ok = 1'b1; lat = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk); #1;
            ibd = w8 ? {idle8, busy8, done8} : {idle16, busy16, done16};
            if (ibd[0]) begin
                seen = 1'b1;
                lat  = k;
                check({nm, " idle/busy at done"}, 64'(ibd), 64'(3'b001));
            end else if (ibd != 3'b010) begin
                flags_ok = 1'b0;
            end
        end
        check({nm, " done seen"}, 64'(seen), 64'(1'b1));
        check({nm, " latency"}, 64'(lat), w8 ? 64'd9 : 64'd17);
        check({nm, " idle/busy during op"}, 64'(flags_ok), 64'(1'b1));
        prod = w8 ? {16'h0, p8} : p16;
        check({nm, " produto"}, 64'(prod), 64'(exp));
        @(posedge clk); #1;
        ibd = w8 ? {idle8, busy8, done8} : {idle16, busy16, done16};
        check({nm, " back to idle"}, 64'(ibd), 64'(3'b100));
        repeat (3) @(posedge clk);
        #1;
        prod = w8 ? {16'h0, p8} : p16;
        check({nm, " produto held"}, 64'(prod), 64'(exp));
    endtask

    initial begin
        int          dcount;
        int          t_first;
        int          t_second;
        logic [31:0] p_at_done;

        vecs.push_back('{"u 5000x6000",  1'b0, 1'b0, 16'd5000, 16'd6000, 32'd30000000});
        vecs.push_back('{"u ffff^2",     1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001});
        vecs.push_back('{"s -1x-1",      1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001});
        vecs.push_back('{"s 8000^2",     1'b0, 1'b1, 16'h8000, 16'h8000, 32'h40000000});
        vecs.push_back('{"s 8000x1",     1'b0, 1'b1, 16'h8000, 16'h0001, 32'hFFFF8000});
        vecs.push_back('{"s 0x-7",       1'b0, 1'b1, 16'h0000, 16'hFFF9, 32'h00000000});
        vecs.push_back('{"s 7x-3",       1'b0, 1'b1, 16'h0007, 16'hFFFD, 32'hFFFFFFEB});
        vecs.push_back('{"u 8000x2",     1'b0, 1'b0, 16'h8000, 16'h0002, 32'h00010000});
        vecs.push_back('{"w8 u ff^2",    1'b1, 1'b0, 16'h00FF, 16'h00FF, 32'h0000FE01});
        vecs.push_back('{"w8 s -128x127", 1'b1, 1'b1, 16'h0080, 16'h007F, 32'h0000C080});
        vecs.push_back('{"w8 s -1x2",    1'b1, 1'b1, 16'h00FF, 16'h0002, 32'h0000FFFE});

        rst = 1'b0;
        st16 = 1'b0; s16 = 1'b0; a16 = '0; b16 = '0;
        st8  = 1'b0; s8  = 1'b0; a8  = '0; b8  = '0;
        #12;
        check("reset flags w16", 64'({idle16, busy16, done16}), 64'(3'b100));
        check("reset produto w16", 64'(p16), 64'd0);
        check("reset flags w8", 64'({idle8, busy8, done8}), 64'(3'b100));
        check("reset produto w8", 64'(p8), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].w8, vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].nm);
        end

        // St pulsed mid-CALC is dropped: one Done, first result only.
        st16 = 1'b1; s16 = 1'b0; a16 = 16'd13; b16 = 16'd10;
        @(posedge clk); #1;
        st16 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        st16 = 1'b1; a16 = 16'd3; b16 = 16'd15;
        @(posedge clk); #1;
        st16 = 1'b0;
        dcount = 0; p_at_done = '0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk); #1;
            if (done16) begin
                dcount++;
                if (dcount == 1) p_at_done = p16;
            end
        end
        check("midcalc done count", 64'(dcount), 64'd1);
        check("midcalc produto", 64'(p_at_done), 64'd130);
        run_op(1'b0, 1'b0, 16'd3, 16'd15, 32'd45, "after midcalc 3x15");

        // St held high: ops start back to back every WIDTH+3 cycles.
        st16 = 1'b1; s16 = 1'b0; a16 = 16'd2; b16 = 16'd3;
        t_first = -1; t_second = -1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (done16) begin
                if (t_first < 0) t_first = k;
                else if (t_second < 0) t_second = k;
            end
        end
        st16 = 1'b0;
        check("held st interval", 64'(t_second - t_first), 64'd19);
        check("held st produto", 64'(p16), 64'd6);
        repeat (25) @(posedge clk);
        #1;

        // Asynchronous reset at CALC iteration 8 aborts with no Done.
        st16 = 1'b1; s16 = 1'b0; a16 = 16'd1234; b16 = 16'd5678;
        @(posedge clk); #1;
        st16 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort flags", 64'({idle16, busy16, done16}), 64'(3'b100));
        check("abort produto", 64'(p16), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        dcount = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done16) dcount++;
        end
        check("abort no done", 64'(dcount), 64'd0);
        run_op(1'b0, 1'b0, 16'd1, 16'd1, 32'd1, "after abort 1x1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
